// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain / UART transmit path.
// State encoding and default frame geometry.
package fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    localparam int DW_DEF  = 8;
    localparam int DIV_DEF = 16;

endpackage

// File: rtl/baud_div.sv
// Bit-period divider: counts 0..DIV-1, wraps on tick.
// A clear restarts the count so each state entry begins a fresh bit.
module baud_div #(
    parameter int DIV = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO consumer: pops one byte per frame and sends it as UART 8N1.
// Line level is decoded from the state register so reset idles txd at once.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int DIV = DIV_DEF
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          Fempty,
    input  logic [DW-1:0] Dout,
    output logic          Ren,
    output logic          txd,
    output logic          busy,
    output logic          tx_done
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] shift_q;
    logic [DW-1:0] shift_d;
    logic [BW-1:0] bit_q;
    logic [BW-1:0] bit_d;
    logic          ren_q;
    logic          tick;
    logic          clr;

    assign clr = (state_d != state_q);

    baud_div #(
        .DIV(DIV)
    ) u_div (
        .ck    (ck),
        .rst   (rst),
        .clr_i (clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!Fempty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_START;
                shift_d = Dout;
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DW - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ren_q   <= (state_d == ST_FETCH);
        end
    end

    assign Ren     = ren_q;
    assign busy    = (state_q != ST_IDLE);
    assign tx_done = (state_q == ST_STOP) && tick;
    assign txd     = (state_q == ST_START) ? 1'b0 :
                     (state_q == ST_DATA)  ? shift_q[0] : 1'b1;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small queue-based FIFO model.
// Line activity is captured per cycle and decoded against hand-computed bytes.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int DIV = 4;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          Fempty = 1'b1;
    logic [DW-1:0] Dout = '0;
    logic          Ren;
    logic          txd;
    logic          busy;
    logic          tx_done;

    always #5 ck = ~ck;

    fifo_uart_tx #(
        .DW (DW),
        .DIV(DIV)
    ) dut (
        .ck     (ck),
        .rst    (rst),
        .Fempty (Fempty),
        .Dout   (Dout),
        .Ren    (Ren),
        .txd    (txd),
        .busy   (busy),
        .tx_done(tx_done)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] q[$];
    bit         force_fe = 1'b0;
    logic       tr[256];
    logic       rr[256];
    logic       dr[256];
    logic       br[256];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock; a byte pops onto Dout the cycle after Ren was high.
    task automatic step();
        logic r;
        r = Ren;
        @(posedge ck);
        #1;
        if (r && q.size() > 0) Dout = q.pop_front();
        if (!force_fe) Fempty = (q.size() == 0);
    endtask

    task automatic capture(input int n, input bit tog);
        for (int i = 0; i < n; i++) begin
            step();
            tr[i] = txd;
            rr[i] = Ren;
            dr[i] = tx_done;
            br[i] = busy;
            if (tog) Fempty = ~Fempty;
        end
    endtask

    function automatic int find_low(input int from, input int n);
        for (int i = from; i < n; i++) if (!tr[i]) return i;
        return -1;
    endfunction

    function automatic int first_ren(input int from, input int n);
        for (int i = from; i < n; i++) if (rr[i]) return i;
        return -1;
    endfunction

    function automatic int first_done(input int from, input int n);
        for (int i = from; i < n; i++) if (dr[i]) return i;
        return -1;
    endfunction

    function automatic int cnt_ren(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (rr[i]) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (dr[i]) c++;
        return c;
    endfunction

    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = tr[s + DIV * (i + 1) + DIV / 2];
        return b;
    endfunction

    function automatic int slot_bad(input int s, input int k, input logic v);
        int c = 0;
        for (int i = 0; i < DIV; i++) if (tr[s + DIV * k + i] !== v) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         s;
        int         s2;
        int         r1;
        int         r2;
        int         found;
        logic [9:0] ex;

        // Reset held with a non-empty FIFO
        #2 rst = 1'b0;
        force_fe = 1'b1;
        Fempty   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rst_hold", {Ren, txd, busy, tx_done}, 4'b0100);
        end
        force_fe = 1'b0;
        q.push_back(8'h3C);
        Fempty = 1'b0;
        rst = 1'b1;
        capture(60, 1'b0);
        check("rst_rel_ren", cnt_ren(60), 1);
        s = find_low(0, 60);
        check("rst_rel_start", (s >= 0), 1);
        if (s < 0) s = 0;
        check("rst_rel_byte", decode(s), 8'h3C);

        // Single byte A5
        q.push_back(8'hA5);
        Fempty = 1'b0;
        capture(60, 1'b0);
        s = find_low(0, 60);
        check("a5_start", (s >= 0), 1);
        if (s < 0) s = 0;
        ex = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_slot%0d", k), slot_bad(s, k, ex[k]), 0);
        end
        check("a5_done_cnt", cnt_done(60), 1);
        check("a5_done_pos", first_done(0, 60), s + 39);
        check("a5_busy_in", br[s], 1);
        check("a5_after", {tr[s + 40], br[s + 40]}, 2'b10);
        check("a5_ren", cnt_ren(60), 1);

        // Empty FIFO
        capture(200, 1'b0);
        check("empty_ren", cnt_ren(200), 0);
        check("empty_txd", find_low(0, 200), -1);

        // Back-to-back 00, FF
        q.push_back(8'h00);
        q.push_back(8'hFF);
        Fempty = 1'b0;
        capture(120, 1'b0);
        check("b2b_ren_cnt", cnt_ren(120), 2);
        r1 = first_ren(0, 120);
        r2 = first_ren(r1 + 1, 120);
        check("b2b_ren_gap", r2 - r1, 43);
        s = find_low(0, 120);
        if (s < 0) s = 0;
        check("b2b_byte0", decode(s), 8'h00);
        s2 = find_low(s + 40, 120);
        check("b2b_idle_gap", s2 - (s + 40), 3);
        if (s2 < 0) s2 = 0;
        check("b2b_byte1", decode(s2), 8'hFF);
        check("b2b_done_cnt", cnt_done(120), 2);

        // Reset during data bit 3 of 0F
        q.push_back(8'h0F);
        Fempty = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (!txd) found = 1;
        end
        check("mid_start", found, 1);
        repeat (DIV * 4 + 1) step();
        check("mid_busy", {busy, txd}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("mid_async", {txd, busy, tx_done, Ren}, 4'b1000);
        repeat (3) step();
        rst = 1'b1;
        capture(20, 1'b0);
        check("mid_no_resid", find_low(0, 20), -1);
        check("mid_no_ren", cnt_ren(20), 0);
        q.push_back(8'h5A);
        Fempty = 1'b0;
        capture(50, 1'b0);
        s = find_low(0, 50);
        if (s < 0) s = 0;
        check("mid_next_byte", decode(s), 8'h5A);
        check("mid_next_done", cnt_done(50), 1);

        // Fempty toggling every cycle during a frame
        q.push_back(8'hC3);
        force_fe = 1'b1;
        Fempty   = 1'b0;
        capture(42, 1'b1);
        check("tog_ren", cnt_ren(42), 1);
        s = find_low(0, 42);
        check("tog_start", s, 2);
        if (s < 0) s = 0;
        check("tog_byte", decode(s), 8'hC3);
        check("tog_done", first_done(0, 42), 41);
        Fempty = 1'b1;
        capture(10, 1'b0);
        check("tog_after_ren", cnt_ren(10), 0);
        check("tog_after_txd", find_low(0, 10), -1);
        force_fe = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
